operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/cpu_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/operand_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU pipeline types and widths.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int c_op_width = 4;

    typedef logic [c_op_width-1:0] opcode_t;

    localparam opcode_t c_op_nop = '0;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Busy bit per register, set on issue and cleared on writeback.
// Revision : 1.0
// ============================================================================
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_addr,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [DEPTH-1:0] o_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_busy_nxt;

    // Addresses at or beyond DEPTH match no index and so touch nothing.
    for (genvar i = 0; i < DEPTH; i++) begin : g_decode
        localparam logic [AW-1:0] c_idx = AW'(i);
        assign w_set[i] = i_set_en && (i_set_addr == c_idx);
        assign w_clr[i] = i_clr_en && (i_clr_addr == c_idx);
    end

    // Set beats clear so a same-cycle reissue keeps the register reserved.
    assign w_busy_nxt = w_set | (r_busy & ~w_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Operand read with writeback bypass, RAW hazard stall, skid-free
//            single output register toward execute.
// Revision : 1.0
// ============================================================================
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int  BUS_WIDTH = 8,
    parameter int  DEPTH     = 3,
    parameter int  OP_WIDTH  = c_op_width,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [AW-1:0]        in_rs_a,
    input  logic [AW-1:0]        in_rs_b,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_rd_we,
    output logic [AW-1:0]        rf_rd_addr_a,
    output logic [AW-1:0]        rf_rd_addr_b,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_a,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_b,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [BUS_WIDTH-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_WIDTH-1:0]  out_op,
    output logic [BUS_WIDTH-1:0] out_opnd_a,
    output logic [BUS_WIDTH-1:0] out_opnd_b,
    output logic [AW-1:0]        out_rd,
    output logic                 out_rd_we
);

    localparam int            c_pad   = 1 << AW;
    localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0]     w_busy;
    logic [c_pad-1:0]     w_busy_pad;
    logic                 w_hit_a;
    logic                 w_hit_b;
    logic                 w_stall_a;
    logic                 w_stall_b;
    logic                 w_hazard;
    logic                 w_accept;
    logic [BUS_WIDTH-1:0] w_opnd_a;
    logic [BUS_WIDTH-1:0] w_opnd_b;

    logic                 r_valid;
    logic [OP_WIDTH-1:0]  r_op;
    logic [BUS_WIDTH-1:0] r_opnd_a;
    logic [BUS_WIDTH-1:0] r_opnd_b;
    logic [AW-1:0]        r_rd;
    logic                 r_rd_we;

    assign rf_rd_addr_a = in_rs_a;
    assign rf_rd_addr_b = in_rs_b;

    assign w_hit_a = wb_we && (wb_addr == in_rs_a);
    assign w_hit_b = wb_we && (wb_addr == in_rs_b);

    // Zero-padded so that non-existent registers read as never busy.
    always_comb begin
        w_busy_pad             = '0;
        w_busy_pad[DEPTH-1:0]  = w_busy;
    end

    assign w_stall_a = w_busy_pad[in_rs_a] && !w_hit_a;
    assign w_stall_b = w_busy_pad[in_rs_b] && !w_hit_b;
    assign w_hazard  = in_valid && (w_stall_a || w_stall_b);

    assign in_ready  = (!r_valid || out_ready) && !w_hazard;
    assign w_accept  = in_valid && in_ready;

    assign w_opnd_a = ({1'b0, in_rs_a} >= c_depth) ? '0 :
                      w_hit_a                      ? wb_data : rf_rd_data_a;
    assign w_opnd_b = ({1'b0, in_rs_b} >= c_depth) ? '0 :
                      w_hit_b                      ? wb_data : rf_rd_data_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_op     <= '0;
            r_opnd_a <= '0;
            r_opnd_b <= '0;
            r_rd     <= '0;
            r_rd_we  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_op     <= in_op;
            r_opnd_a <= w_opnd_a;
            r_opnd_b <= w_opnd_b;
            r_rd     <= in_rd;
            r_rd_we  <= in_rd_we;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_accept && in_rd_we),
        .i_set_addr (in_rd),
        .i_clr_en   (wb_we),
        .i_clr_addr (wb_addr),
        .o_busy     (w_busy)
    );

    assign out_valid  = r_valid;
    assign out_op     = r_op;
    assign out_opnd_a = r_opnd_a;
    assign out_opnd_b = r_opnd_b;
    assign out_rd     = r_rd;
    assign out_rd_we  = r_rd_we;

endmodule
`default_nettype wire
